// File: rtl/vx_tcu_lsu_tile_req_if.sv
// Tensor-core descriptor port and LSU row-request port of the tile engine.
// The engine itself attaches through the slave modport.
`ifndef XLEN
`define XLEN 32
`endif

interface vx_tcu_lsu_tile_req_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = `XLEN,
  parameter int MAX_ROWS     = 16
);
  localparam int ROW_W = $clog2(MAX_ROWS + 1);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]            tcu_req_valid;
  logic [NUM_CHANNELS-1:0]            tcu_req_ready;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] tcu_req_base;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] tcu_req_stride;
  logic [NUM_CHANNELS*ROW_W-1:0]      tcu_req_rows;
  logic [NUM_CHANNELS-1:0]            tcu_req_load;
  logic [NUM_CHANNELS-1:0]            tcu_done;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_WIDTH-1:0] lsu_req_addr;
  logic                  lsu_req_load;
  logic [CH_W-1:0]       lsu_req_chan;
  logic [ROW_W-1:0]      lsu_req_row;
  logic                  lsu_req_last;
  logic                  lsu_rsp_valid;

  modport master (
    output tcu_req_valid, tcu_req_base, tcu_req_stride,
    output tcu_req_rows, tcu_req_load,
    output lsu_req_ready, lsu_rsp_valid,
    input  tcu_req_ready, tcu_done,
    input  lsu_req_valid, lsu_req_addr, lsu_req_load,
    input  lsu_req_chan, lsu_req_row, lsu_req_last
  );

  modport slave (
    input  tcu_req_valid, tcu_req_base, tcu_req_stride,
    input  tcu_req_rows, tcu_req_load,
    input  lsu_req_ready, lsu_rsp_valid,
    output tcu_req_ready, tcu_done,
    output lsu_req_valid, lsu_req_addr, lsu_req_load,
    output lsu_req_chan, lsu_req_row, lsu_req_last
  );
endinterface

// File: rtl/vx_tcu_lsu_tile_req.sv
// Tile request engine: round-robin descriptor grant, one LSU
// request per row, credit-bounded in-flight rows, per-channel done.
`ifndef XLEN
`define XLEN 32
`endif

module vx_tcu_lsu_tile_req #(
  parameter int NUM_CHANNELS    = 2,
  parameter int ADDR_WIDTH      = `XLEN,
  parameter int MAX_ROWS        = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic reset_n,
  vx_tcu_lsu_tile_req_if.slave bus,
  output logic busy
);
  localparam int ROW_W = $clog2(MAX_ROWS + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_nx;

  logic [CH_W-1:0]       rr_ptr, chan, gnt;
  logic                  gnt_ok;
  logic [CNT_W-1:0]      outstanding, out_nx;
  logic [ADDR_WIDTH-1:0] addr, stride;
  logic [ROW_W-1:0]      rows, row, rows_in, rows_cl;
  logic                  load, fire, last, credit, done;

  function automatic logic [CH_W-1:0] wrap_add(
    logic [CH_W-1:0] a, int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CHANNELS) s = s - NUM_CHANNELS;
    return CH_W'(s);
  endfunction

  always_comb begin
    gnt_ok = 1'b0;
    gnt    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!gnt_ok && bus.tcu_req_valid[wrap_add(rr_ptr, i)]) begin
        gnt_ok = 1'b1;
        gnt    = wrap_add(rr_ptr, i);
      end
    end
  end

  assign rows_in = bus.tcu_req_rows[gnt*ROW_W +: ROW_W];
  assign rows_cl = (rows_in > ROW_W'(MAX_ROWS)) ?
                   ROW_W'(MAX_ROWS) : rows_in;

  // Credit check uses the count registered at the start of the cycle.
  assign credit = outstanding < CNT_W'(MAX_OUTSTANDING);
  assign last   = (row == rows - ROW_W'(1));
  assign fire   = bus.lsu_req_valid & bus.lsu_req_ready;
  assign done   = (state == DRAIN) && (outstanding == '0);

  assign out_nx = outstanding + CNT_W'(fire)
                - CNT_W'(bus.lsu_rsp_valid && outstanding != '0);

  assign bus.lsu_req_valid = (state == ISSUE) && credit;
  assign bus.lsu_req_addr  = addr;
  assign bus.lsu_req_load  = load;
  assign bus.lsu_req_chan  = chan;
  assign bus.lsu_req_row   = row;
  assign bus.lsu_req_last  = (state == ISSUE) && last;
  assign busy              = (state != IDLE);

  always_comb begin
    state_nx          = state;
    bus.tcu_req_ready = '0;
    bus.tcu_done      = '0;
    unique case (state)
      IDLE: begin
        if (gnt_ok) begin
          bus.tcu_req_ready[gnt] = reset_n;
          state_nx = (rows_cl != '0) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        if (fire && last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (done) begin
          bus.tcu_done[chan] = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      outstanding <= '0;
      addr        <= '0;
      stride      <= '0;
      rows        <= '0;
      row         <= '0;
      load        <= 1'b0;
      chan        <= '0;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;
      if (state == IDLE && gnt_ok) begin
        addr   <= bus.tcu_req_base[gnt*ADDR_WIDTH +: ADDR_WIDTH];
        stride <= bus.tcu_req_stride[gnt*ADDR_WIDTH +: ADDR_WIDTH];
        rows   <= rows_cl;
        row    <= '0;
        load   <= bus.tcu_req_load[gnt];
        chan   <= gnt;
      end
      if (fire) begin
        addr <= addr + stride;
        row  <= row + ROW_W'(1);
      end
      if (done) rr_ptr <= wrap_add(chan, 1);
    end
  end
endmodule

// File: tb/tb_vx_tcu_lsu_tile_req.sv
// Randomized scoreboard bench for the tile request engine.
// Row-level reference model; monitor compares every cycle.
module tb_vx_tcu_lsu_tile_req;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int MR = 16;
  localparam int MO = 8;
  localparam int RW = $clog2(MR + 1);
  localparam int CW = 1;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [RW-1:0] rows;
    logic          load;
  } desc_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          load;
    logic [CW-1:0] chan;
    logic [RW-1:0] row;
    logic          last;
  } req_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  vx_tcu_lsu_tile_req_if #(
    .NUM_CHANNELS(N), .ADDR_WIDTH(AW), .MAX_ROWS(MR)
  ) bus ();

  vx_tcu_lsu_tile_req #(
    .NUM_CHANNELS(N), .ADDR_WIDTH(AW),
    .MAX_ROWS(MR), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy)
  );

  desc_t         dq [N][$];
  req_t          expq[$];
  int            due_q[$];
  logic [CW-1:0] done_log[$];
  bit            taken [N];

  int errors = 0, checks = 0, cyc = 0, fires = 0;
  bit in_flight = 0;
  logic [CW-1:0] cur_chan = '0;
  int rr_m = 0, model_out = 0, acc_cyc = 0, acc_rows = 0;
  int lat = 2, release_n = 0;
  bit hold = 0, stray = 0, rdy_rand = 0, rand_lat = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void push_desc(int ch, logic [AW-1:0] b,
      logic [AW-1:0] s, int r, bit ld);
    desc_t d;
    d.base = b; d.stride = s; d.rows = RW'(r); d.load = ld;
    dq[ch].push_back(d);
  endfunction

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin : mon
    logic [N-1:0] er, ed;
    int g, c, rws, dl;
    bit fire, rsp;
    req_t act, e;
    logic [AW-1:0] b, s;
    cyc++;
    if (!reset_n) begin
      expq.delete(); due_q.delete();
      in_flight = 0; rr_m = 0; model_out = 0;
    end else begin
      er = '0; g = -1;
      if (!in_flight)
        for (int i = 0; i < N; i++) begin
          c = (rr_m + i) % N;
          if (g < 0 && bus.tcu_req_valid[c]) g = c;
        end
      if (g >= 0) er[g] = 1'b1;
      chk("tcu_req_ready", bus.tcu_req_ready, er);
      chk("busy", busy, in_flight);
      chk("lsu_req_valid", bus.lsu_req_valid,
          in_flight && expq.size() > 0 && model_out < MO);
      if (bus.lsu_req_valid) begin
        act = {bus.lsu_req_addr, bus.lsu_req_load,
               bus.lsu_req_chan, bus.lsu_req_row,
               bus.lsu_req_last};
        if (expq.size() == 0) chk("lsu_req_extra", act, '0);
        else chk("lsu_req", act, expq[0]);
      end
      ed = '0;
      if (in_flight && expq.size() == 0 && model_out == 0)
        ed[cur_chan] = 1'b1;
      chk("tcu_done", bus.tcu_done, ed);
      fire = bus.lsu_req_valid && bus.lsu_req_ready;
      if (fire) begin
        if (expq.size() > 0) void'(expq.pop_front());
        fires++;
        dl = rand_lat ? int'($urandom_range(1, 4)) : lat;
        due_q.push_back(cyc + dl);
      end
      rsp = bus.lsu_rsp_valid && model_out > 0;
      model_out = model_out + int'(fire) - int'(rsp);
      if (ed != '0) begin
        done_log.push_back(cur_chan);
        if (acc_rows == 0) chk("zero_row_latency", cyc - acc_cyc, 1);
        in_flight = 0;
        rr_m = (int'(cur_chan) + 1) % N;
      end
      if (g >= 0) begin
        b   = bus.tcu_req_base[g*AW +: AW];
        s   = bus.tcu_req_stride[g*AW +: AW];
        rws = int'(bus.tcu_req_rows[g*RW +: RW]);
        if (rws > MR) rws = MR;
        for (int r = 0; r < rws; r++) begin
          e.addr = b + s * AW'(r);
          e.load = bus.tcu_req_load[g];
          e.chan = CW'(g);
          e.row  = RW'(r);
          e.last = (r == rws - 1);
          expq.push_back(e);
        end
        in_flight = 1; cur_chan = CW'(g);
        acc_cyc = cyc; acc_rows = rws; taken[g] = 1;
      end
    end
  end

  // Descriptor drivers and LSU model, driven just after the edge.
  always @(posedge clk) begin : drv
    desc_t d;
    #1;
    bus.lsu_rsp_valid = 1'b0;
    if (!reset_n) begin
      bus.tcu_req_valid = '0;
      bus.lsu_req_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
        dq[i].delete(); taken[i] = 0;
      end
      due_q.delete();
    end else begin
      if (stray) begin
        bus.lsu_rsp_valid = 1'b1; stray = 0;
      end else if (due_q.size() > 0 && due_q[0] <= cyc &&
                   (!hold || release_n > 0)) begin
        void'(due_q.pop_front());
        bus.lsu_rsp_valid = 1'b1;
        if (hold) release_n--;
      end
      bus.lsu_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (taken[i]) begin
          taken[i] = 0; bus.tcu_req_valid[i] = 1'b0;
        end
        if (!bus.tcu_req_valid[i] && dq[i].size() > 0) begin
          d = dq[i].pop_front();
          bus.tcu_req_valid[i] = 1'b1;
          bus.tcu_req_base[i*AW +: AW]   = d.base;
          bus.tcu_req_stride[i*AW +: AW] = d.stride;
          bus.tcu_req_rows[i*RW +: RW]   = d.rows;
          bus.tcu_req_load[i]            = d.load;
        end
      end
    end
  end

  task automatic wait_idle(string name);
    int n = 0;
    while (n < 3000 && !(dq[0].size() == 0 && dq[1].size() == 0 &&
           bus.tcu_req_valid == '0 && !in_flight &&
           due_q.size() == 0)) begin
      @(negedge clk); #1; n++;
    end
    chk({name, "_timeout"}, n < 3000, 1);
  endtask

  task automatic wait_fires(int target);
    int n = 0;
    while (fires < target && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("fire_wait_timeout", n < 200, 1);
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.tcu_req_ready, bus.tcu_done, bus.lsu_req_valid,
            bus.lsu_req_addr, bus.lsu_req_load, bus.lsu_req_chan,
            bus.lsu_req_row, bus.lsu_req_last, busy};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int f0;
    bus.tcu_req_valid = '0; bus.tcu_req_base = '0;
    bus.tcu_req_stride = '0; bus.tcu_req_rows = '0;
    bus.tcu_req_load = '0; bus.lsu_req_ready = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk); #1;
    chk("reset_outputs", all_outs(), '0);

    // single load tile
    push_desc(0, 32'h1000, 32'h40, 4, 1);
    wait_idle("single");
    chk("single_done_count", done_log.size(), 1);
    if (done_log.size() > 0) chk("single_done_chan", done_log[0], 0);
    done_log.delete();

    // fairness with both channels saturated
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < N; ch++)
        push_desc(ch, $urandom, $urandom_range(1, 255), 2, k[0]);
    wait_idle("fair");
    chk("fair_done_count", done_log.size(), 6);
    for (int k = 1; k < done_log.size(); k++)
      chk("fair_alternate", done_log[k] != done_log[k-1], 1);
    done_log.delete();

    // credit stall
    hold = 1; release_n = 0; lat = 1;
    f0 = fires;
    push_desc(0, 32'h2000, 32'h10, 12, 0);
    wait_fires(f0 + 8);
    repeat (5) @(negedge clk);
    chk("credit_stall_fires", fires - f0, 8);
    release_n = 1;
    repeat (6) @(negedge clk);
    chk("credit_one_more", fires - f0, 9);
    hold = 0;
    wait_idle("credit");

    // backpressure with address wrap, then random tiles
    rdy_rand = 1; rand_lat = 1;
    push_desc(1, 32'hFFFF_FFC0, 32'h40, 3, 1);
    wait_idle("wrap");
    for (int k = 0; k < 24; k++)
      push_desc($urandom_range(0, 1), $urandom, $urandom,
                $urandom_range(0, 31), $urandom_range(0, 1));
    wait_idle("random");
    rdy_rand = 0; rand_lat = 0; lat = 2;

    // zero-row store and stray response
    done_log.delete();
    push_desc(1, 32'h3000, 32'h20, 0, 0);
    wait_idle("zero_row");
    chk("zero_row_done", done_log.size(), 1);
    @(negedge clk); #1;
    stray = 1;
    repeat (3) @(negedge clk);
    push_desc(0, 32'h4000, 32'h8, 10, 1);
    wait_idle("after_stray");

    // reset in the middle of a tile
    hold = 1; release_n = 0;
    f0 = fires;
    push_desc(0, 32'h5000, 32'h100, 8, 1);
    wait_fires(f0 + 3);
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    hold = 0;
    @(negedge clk); #1;
    chk("midtile_reset_outputs", all_outs(), '0);
    done_log.delete();
    push_desc(1, 32'h6000, 32'h4, 2, 0);
    push_desc(0, 32'h7000, 32'h4, 2, 1);
    wait_idle("post_reset");
    chk("post_reset_count", done_log.size(), 2);
    if (done_log.size() > 0) chk("post_reset_first", done_log[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
